// File: rtl/td4_ctl_pkg.sv
// Shared definitions for the TD4 run controller: state and command codes,
// the self-jump opcode nibble and the program memory depth.
package td4_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_HALTED   = 2'b01,
    ST_RUNNING  = 2'b10,
    ST_STEPPING = 2'b11
  } td4_state_e;

  typedef enum logic [1:0] {
    CMD_RESET_CPU = 2'b00,
    CMD_RUN       = 2'b01,
    CMD_STEP      = 2'b10,
    CMD_HALT      = 2'b11
  } td4_cmd_e;

  localparam logic [3:0] JMP_OPC   = 4'b1111;
  localparam int         MEM_DEPTH = 16;

  // A TD4 "JMP imm" whose immediate equals its own address never leaves.
  function automatic logic is_self_jump(logic [7:0] instr, logic [3:0] addr);
    return instr == {JMP_OPC, addr};
  endfunction

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 program memory for the TD4 core: async clear to 0x00, one
// synchronous write port, one combinational read port.
module td4_prog_mem
  import td4_ctl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [MEM_DEPTH];

  // Storage: cleared by reset, written one byte per accepted load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_run_controller.sv
// Run controller for the TD4 core. Owns program memory and sequences the
// core through IDLE / HALTED / RUNNING / STEPPING, stopping automatically on
// a self-jump. Optional breakpoint logic is built when TD4CTL_BREAKPOINT_EN
// is defined; otherwise the bp_* ports do not exist.
//
// state    | meaning
// IDLE     | core held in clear, no clock enable
// HALTED   | core released, no clock enable
// RUNNING  | CE once every RUN_DIV cycles
// STEPPING | exactly one CE cycle, then HALTED
module td4_run_controller
  import td4_ctl_pkg::*;
#(
  parameter int unsigned RUN_DIV = 1
) (
  input  logic       clk_i,
  input  logic       clr_n_i,
  input  logic       ld_valid_i,
  output logic       ld_ready_o,
  input  logic [3:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [3:0] cpu_a_i,
  output logic [7:0] cpu_d_o,
  output logic       cpu_clr_o,
  output logic       cpu_ce_o,
  output logic [1:0] state_o,
  output logic       self_loop_o,
`ifdef TD4CTL_BREAKPOINT_EN
  input  logic [3:0] bp_addr_i,
  input  logic       bp_en_i,
  output logic       bp_hit_o,
`endif
  output logic [7:0] instr_count_o
);

  localparam logic [15:0] DIV_TC = 16'(RUN_DIV - 1);

  td4_state_e state_q, state_d;
  td4_cmd_e   cmd;
  logic [15:0] div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cpu_clr_q;
  logic        self_loop_q, self_loop_d;
  logic        cmd_acc, reset_cmd, run_opp, ce, self_jump, bp_stop;

  assign cmd = td4_cmd_e'(cmd_i);

  td4_prog_mem u_mem (
    .clk_i   (clk_i),
    .rst_n_i (clr_n_i),
    .we_i    (ld_valid_i & ld_ready_o),
    .waddr_i (ld_addr_i),
    .wdata_i (ld_data_i),
    .raddr_i (cpu_a_i),
    .rdata_o (cpu_d_o)
  );

  assign ld_ready_o  = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign cmd_ready_o = (state_q != ST_STEPPING);
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign reset_cmd   = cmd_acc && (cmd == CMD_RESET_CPU);
  assign run_opp     = (state_q == ST_RUNNING) && (div_q == DIV_TC);

`ifdef TD4CTL_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic first_q, first_d;

  // The first CE opportunity after entering RUNNING bypasses the check so
  // that RUN resumes past the breakpoint it stopped on.
  assign bp_stop  = run_opp && !first_q && bp_en_i && (cpu_a_i == bp_addr_i);
  assign bp_hit_d = reset_cmd ? 1'b0 : (bp_hit_q | bp_stop);
  assign first_d  = (state_q != ST_RUNNING) ? 1'b1 : (run_opp ? 1'b0 : first_q);
  assign bp_hit_o = bp_hit_q;
`else
  assign bp_stop  = 1'b0;
`endif

  assign ce          = (run_opp && !bp_stop) || (state_q == ST_STEPPING);
  assign self_jump   = ce && is_self_jump(cpu_d_o, cpu_a_i);
  assign cnt_d       = reset_cmd ? 8'h00 : cnt_q + {7'b0, ce};
  assign self_loop_d = reset_cmd ? 1'b0 : (self_loop_q | self_jump);

  // Next-state decode; RESET_CPU outranks a self-jump halt in RUNNING.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (cmd_acc) begin
          unique case (cmd)
            CMD_RESET_CPU: state_d = ST_IDLE;
            CMD_RUN:       state_d = ST_RUNNING;
            CMD_STEP:      state_d = ST_STEPPING;
            CMD_HALT:      state_d = ST_HALTED;
            default:       state_d = state_q;
          endcase
        end
      end
      ST_RUNNING: begin
        if (reset_cmd)                                   state_d = ST_IDLE;
        else if (self_jump || bp_stop)                   state_d = ST_HALTED;
        else if (cmd_acc && (cmd == CMD_HALT || cmd == CMD_STEP))
                                                         state_d = ST_HALTED;
      end
      ST_STEPPING: state_d = ST_HALTED;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Divider only counts while staying in RUNNING, so every entry starts at 0.
  always_comb begin
    div_d = 16'h0000;
    if (state_q == ST_RUNNING && state_d == ST_RUNNING)
      div_d = (div_q == DIV_TC) ? 16'h0000 : div_q + 16'd1;
  end

  // Controller registers: state, divider, core clear, flags and counter.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q     <= ST_IDLE;
      div_q       <= 16'h0000;
      cpu_clr_q   <= 1'b0;
      self_loop_q <= 1'b0;
      cnt_q       <= 8'h00;
`ifdef TD4CTL_BREAKPOINT_EN
      bp_hit_q    <= 1'b0;
      first_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cpu_clr_q   <= (state_d != ST_IDLE);
      self_loop_q <= self_loop_d;
      cnt_q       <= cnt_d;
`ifdef TD4CTL_BREAKPOINT_EN
      bp_hit_q    <= bp_hit_d;
      first_q     <= first_d;
`endif
    end
  end

  assign cpu_clr_o     = cpu_clr_q;
  assign cpu_ce_o      = ce;
  assign state_o       = state_q;
  assign self_loop_o   = self_loop_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_td4_run_controller.sv
// Bench for td4_run_controller: two instances (RUN_DIV=1 and RUN_DIV=4) share
// stimulus; each has a tiny TD4 core stand-in driving its address bus.
module tb_td4_run_controller;

  logic clk, clr_n, ld_valid, cmd_valid;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] cmd;
  logic [1:0][3:0] ca;
  logic [1:0][7:0] dd, cnt;
  logic [1:0][1:0] st;
  logic [1:0] ldr, cmdr, clro, ce, slo;
`ifdef TD4CTL_BREAKPOINT_EN
  logic [3:0] bp_addr;
  logic bp_en;
  logic [1:0] bph;
`endif

  td4_run_controller #(.RUN_DIV(1)) dut1 (
    .clk_i(clk), .clr_n_i(clr_n), .ld_valid_i(ld_valid), .ld_ready_o(ldr[0]),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmdr[0]), .cmd_i(cmd), .cpu_a_i(ca[0]), .cpu_d_o(dd[0]),
    .cpu_clr_o(clro[0]), .cpu_ce_o(ce[0]), .state_o(st[0]), .self_loop_o(slo[0]),
`ifdef TD4CTL_BREAKPOINT_EN
    .bp_addr_i(bp_addr), .bp_en_i(bp_en), .bp_hit_o(bph[0]),
`endif
    .instr_count_o(cnt[0]));

  td4_run_controller #(.RUN_DIV(4)) dut4 (
    .clk_i(clk), .clr_n_i(clr_n), .ld_valid_i(ld_valid), .ld_ready_o(ldr[1]),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmdr[1]), .cmd_i(cmd), .cpu_a_i(ca[1]), .cpu_d_o(dd[1]),
    .cpu_clr_o(clro[1]), .cpu_ce_o(ce[1]), .state_o(st[1]), .self_loop_o(slo[1]),
`ifdef TD4CTL_BREAKPOINT_EN
    .bp_addr_i(bp_addr), .bp_en_i(bp_en), .bp_hit_o(bph[1]),
`endif
    .instr_count_o(cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model (states: 0 idle, 1 halted, 2 running, 3 stepping).
  int m_st[2], m_phase[2], m_opps[2], m_cnt[2];
  bit m_sl[2], m_bp[2], m_clr[2];
  logic [7:0] m_mem[2][16];
  int pc[2];
  int a_ovr;

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit m_opp(int k);
    return (m_st[k] == 2) && ((m_phase[k] % div_of(k)) == div_of(k) - 1);
  endfunction

  function automatic bit m_bpstop(int k);
`ifdef TD4CTL_BREAKPOINT_EN
    return m_opp(k) && (m_opps[k] > 0) && bp_en && (ca[k] == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ce(int k);
    return (m_st[k] == 3) || (m_opp(k) && !m_bpstop(k));
  endfunction

  function automatic bit act_bp(int k);
`ifdef TD4CTL_BREAKPOINT_EN
    return bph[k];
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_phase[k] = 0; m_opps[k] = 0; m_cnt[k] = 0;
      m_sl[k] = 0; m_bp[k] = 0; m_clr[k] = 0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = 8'h00;
    end
  endfunction

  function automatic void model_step(int k);
    bit cem, sj, bps, opp, acc;
    int nst;
    opp = m_opp(k);
    bps = m_bpstop(k);
    cem = m_ce(k);
    sj  = cem && (m_mem[k][ca[k]] == {4'hF, ca[k]});
    acc = cmd_valid && (m_st[k] != 3);
    nst = m_st[k];
    if (ld_valid && m_st[k] <= 1) m_mem[k][ld_addr] = ld_data;
    if (acc && cmd == 2'd0) begin
      nst = 0; m_cnt[k] = 0; m_sl[k] = 0; m_bp[k] = 0;
    end else begin
      m_cnt[k] = (m_cnt[k] + int'(cem)) % 256;
      if (sj) m_sl[k] = 1;
      if (bps) m_bp[k] = 1;
      case (m_st[k])
        0, 1: if (acc) begin
          if (cmd == 2'd1) begin nst = 2; m_phase[k] = 0; m_opps[k] = 0; end
          else if (cmd == 2'd2) nst = 3;
          else nst = 1;
        end
        2: if (sj || bps || (acc && cmd != 2'd1)) nst = 1;
           else begin m_phase[k]++; if (opp) m_opps[k]++; end
        default: nst = 1;
      endcase
    end
    m_st[k] = nst;
    m_clr[k] = (nst != 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] act_vec(int k);
    return {st[k], ce[k], clro[k], ldr[k], cmdr[k], slo[k], act_bp(k), cnt[k], dd[k]};
  endfunction

  function automatic logic [23:0] exp_vec(int k);
    return {2'(m_st[k]), m_ce(k), m_clr[k], (m_st[k] <= 1), (m_st[k] != 3),
            m_sl[k], m_bp[k], 8'(m_cnt[k]), m_mem[k][ca[k]]};
  endfunction

  task automatic check_model(string name);
    chk({name, "_div1"}, 32'(act_vec(0)), 32'(exp_vec(0)));
    chk({name, "_div4"}, 32'(act_vec(1)), 32'(exp_vec(1)));
  endtask

  // One clock: model and core stand-in see the pre-edge values.
  task automatic tick();
    bit ce_s[2], clr_s[2];
    logic [7:0] d_s[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      ce_s[k] = ce[k]; clr_s[k] = clro[k]; d_s[k] = dd[k];
      model_step(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!clr_s[k]) pc[k] = 0;
      else if (ce_s[k]) pc[k] = (d_s[k][7:4] == 4'hF) ? int'(d_s[k][3:0]) : (pc[k] + 1) % 16;
      ca[k] = (a_ovr < 0) ? 4'(pc[k]) : 4'(a_ovr);
    end
    #1;
  endtask

  task automatic set_a(int v);
    a_ovr = v;
    for (int k = 0; k < 2; k++) ca[k] = (v < 0) ? 4'(pc[k]) : 4'(v);
    #1;
  endtask

  task automatic do_cmd(logic [1:0] c);
    cmd_valid = 1'b1; cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(logic [3:0] a, logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  typedef struct packed {
    bit v; logic [1:0] c; logic [1:0] e_st; bit e_ldr; bit e_cmdr; bit e_clr;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    logic [15:0] mask;
    bit any_ce;

    tbl[0]  = '{1, 2'd0, 2'd0, 1, 1, 0};
    tbl[1]  = '{1, 2'd3, 2'd1, 1, 1, 1};
    tbl[2]  = '{1, 2'd3, 2'd1, 1, 1, 1};
    tbl[3]  = '{1, 2'd1, 2'd2, 0, 1, 1};
    tbl[4]  = '{1, 2'd1, 2'd2, 0, 1, 1};
    tbl[5]  = '{1, 2'd2, 2'd1, 1, 1, 1};
    tbl[6]  = '{1, 2'd2, 2'd3, 0, 0, 1};
    tbl[7]  = '{1, 2'd1, 2'd1, 1, 1, 1};
    tbl[8]  = '{0, 2'd1, 2'd1, 1, 1, 1};
    tbl[9]  = '{1, 2'd0, 2'd0, 1, 1, 0};
    tbl[10] = '{1, 2'd2, 2'd3, 0, 0, 1};
    tbl[11] = '{0, 2'd0, 2'd1, 1, 1, 1};
    tbl[12] = '{1, 2'd1, 2'd2, 0, 1, 1};
    tbl[13] = '{1, 2'd0, 2'd0, 1, 1, 0};

    clr_n = 1'b0; ld_valid = 0; cmd_valid = 0; ld_addr = 0; ld_data = 0; cmd = 0;
`ifdef TD4CTL_BREAKPOINT_EN
    bp_addr = 0; bp_en = 0;
`endif
    a_ovr = -1; pc[0] = 0; pc[1] = 0; ca = '0;
    model_reset();
    #12;
    chk("reset_div1", 32'(act_vec(0)), 32'h0C0000);
    chk("reset_div4", 32'(act_vec(1)), 32'h0C0000);
    clr_n = 1'b1;

    // Command response table (memory all zero, no self-jumps possible).
    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].v; cmd = tbl[i].c;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++)
        chk($sformatf("tbl%0d_k%0d", i, k), {27'b0, st[k], ldr[k], cmdr[k], clro[k]},
            {27'b0, tbl[i].e_st, tbl[i].e_ldr, tbl[i].e_cmdr, tbl[i].e_clr});
      check_model($sformatf("tbl%0d_model", i));
    end

    // Program with a self-jump at address 2; RUN_DIV=1 runs three CEs and stops.
    do_load(4'd0, 8'h31);
    do_load(4'd1, 8'h32);
    do_load(4'd2, 8'hF2);
    do_cmd(2'd1);
    chk("run_clr_st", {30'b0, clro[0], st[0][1]}, 32'h3);
    for (int i = 0; i < 4; i++) begin
      pat[i] = ce[0];
      if (i < 3) tick();
    end
    chk("selfjump_ce_pattern", 32'(pat), 32'h7);
    chk("selfjump_state_sl_cnt", {21'b0, st[0], slo[0], cnt[0]}, {21'b0, 2'd1, 1'b1, 8'd3});
    for (int i = 0; i < 12; i++) tick();
    chk("selfjump_div4", {21'b0, st[1], slo[1], cnt[1]}, {21'b0, 2'd1, 1'b1, 8'd3});

    // Two single steps from HALTED.
    for (int s = 0; s < 2; s++) begin
      do_cmd(2'd2);
      chk($sformatf("step%0d_in", s), {28'b0, st[0], cmdr[0], ce[0]}, {28'b0, 2'd3, 1'b0, 1'b1});
      tick();
      chk($sformatf("step%0d_out", s), {29'b0, st[0], ce[0]}, {29'b0, 2'd1, 1'b0});
    end
    chk("step_count", 32'(cnt[0]), 32'd5);
    check_model("after_step");

    // RUN_DIV=4 cadence, then HALT.
    do_cmd(2'd0);
    chk("reset_cpu_div4", {20'b0, st[1], clro[1], slo[1], cnt[1]}, 32'h0);
    do_load(4'd2, 8'h00);
    do_cmd(2'd1);
    for (int i = 0; i < 16; i++) begin
      mask[i] = ce[1];
      if (i == 15) begin cmd_valid = 1'b1; cmd = 2'd3; end
      tick();
    end
    cmd_valid = 1'b0;
    chk("div4_ce_mask", 32'(mask), 32'h8888);
    chk("div4_halt_cnt", {22'b0, st[1], cnt[1]}, {22'b0, 2'd1, 8'd4});
    any_ce = 0;
    for (int i = 0; i < 3; i++) begin any_ce |= ce[1]; tick(); end
    chk("div4_no_ce_after_halt", 32'(any_ce), 32'd0);
    check_model("after_div4");

    // Load refused while running; RESET_CPU clears; load + command together.
    do_cmd(2'd1);
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 8'hA5;
    #1;
    chk("ld_ready_running", {30'b0, ldr[1], st[1] == 2'd2}, 32'h1);
    tick();
    ld_valid = 1'b0;
    do_cmd(2'd0);
    chk("reset_cpu_clears", {20'b0, st[1], clro[1], slo[1], cnt[1]}, 32'h0);
    set_a(5);
    chk("mem_unchanged", {16'b0, dd[1], dd[0]}, 32'h0);
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 8'h77; cmd_valid = 1'b1; cmd = 2'd3;
    tick();
    ld_valid = 1'b0; cmd_valid = 1'b0;
    set_a(7);
    chk("load_and_cmd", {22'b0, st[1], dd[1]}, {22'b0, 2'd1, 8'h77});
    set_a(-1);
    check_model("after_load");

`ifdef TD4CTL_BREAKPOINT_EN
    do_cmd(2'd0);
    bp_addr = 4'd1; bp_en = 1'b1;
    do_cmd(2'd1);
    chk("bp_first_ce", 32'(ce[0]), 32'd1);
    tick();
    chk("bp_suppressed", 32'(ce[0]), 32'd0);
    tick();
    chk("bp_halt", {21'b0, st[0], bph[0], cnt[0]}, {21'b0, 2'd1, 1'b1, 8'd1});
    do_cmd(2'd1);
    chk("bp_resume", {26'b0, st[0], ce[0], ca[0]}, {26'b0, 2'd2, 1'b1, 4'd1});
    tick();
    chk("bp_sticky", 32'(bph[0]), 32'd1);
    check_model("after_bp");
    bp_en = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a_ovr = $urandom_range(0, 15);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd = 2'($urandom);
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_addr = 4'($urandom);
      ld_data = $urandom_range(0, 1) ? {4'hF, 4'($urandom)} : 8'($urandom);
`ifdef TD4CTL_BREAKPOINT_EN
      bp_en = ($urandom_range(0, 3) == 0);
      bp_addr = 4'($urandom);
`endif
      tick();
      check_model($sformatf("rand%0d", i));
    end
    cmd_valid = 1'b0; ld_valid = 1'b0;
`ifdef TD4CTL_BREAKPOINT_EN
    bp_en = 1'b0;
`endif
    set_a(-1);

    // Asynchronous clear in the middle of a run.
    do_cmd(2'd0);
    do_load(4'd0, 8'h31);
    do_cmd(2'd1);
    tick();
    tick();
    set_a(0);
    #3;
    clr_n = 1'b0;
    model_reset();
    pc[0] = 0; pc[1] = 0;
    #1;
    chk("async_clr_div1", 32'(act_vec(0)), 32'h0C0000);
    chk("async_clr_div4", 32'(act_vec(1)), 32'h0C0000);
    #10;
    clr_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
